// File: rtl/compress_stage_ctrl.sv
`default_nettype none
// compress_stage_ctrl: block sequencer feeding word pairs into the matching stage
// and tracking result validity out to the packer. Rev 1.0
module compress_stage_ctrl #(
  parameter int WIDTH       = 64,
  parameter int BLOCK_PAIRS = 512,
  parameter int PIPE_LAT    = 2,
  parameter int CNT_W       = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_word,
  output logic             o_stage_en,
  output logic             o_dict_wr_en,
  output logic             o_dict_clear,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_PAIRS - 1);

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [PIPE_LAT-1:0] vld;
  logic [PIPE_LAT-1:0] lst;
  logic                wr_en;
  logic                advance;
  logic                in_ready;
  logic                stage_en;
  logic                accept;
  logic                take;
  logic                last_take;
  logic                aborting;

  // The stage may move whenever its output slot is empty or being drained.
  assign advance   = !vld[PIPE_LAT-1] || i_out_ready;
  assign aborting  = i_abort && (state != IDLE);
  assign accept    = i_in_valid && in_ready;
  assign take      = accept && !i_abort;
  assign last_take = take && (cnt == LAST_IDX);

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    stage_en   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) next_state = CLEAR;
      end
      CLEAR: begin
        next_state = RUN;
      end
      RUN: begin
        in_ready = advance;
        stage_en = advance;
        if (i_in_valid && advance && (cnt == LAST_IDX)) next_state = DRAIN;
      end
      DRAIN: begin
        stage_en = advance;
        if (vld == '0) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (aborting) next_state = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      vld    <= '0;
      lst    <= '0;
      wr_en  <= 1'b0;
      o_word <= '0;
    end else begin
      state <= next_state;
      wr_en <= take;
      if (aborting) begin
        cnt <= '0;
        vld <= '0;
        lst <= '0;
      end else begin
        if (state == CLEAR) cnt <= '0;
        if (take) begin
          o_word <= i_in_data;
          cnt    <= last_take ? '0 : cnt + 1'b1;
        end
        if (stage_en) begin
          for (int i = PIPE_LAT - 1; i > 0; i--) begin
            vld[i] <= vld[i-1];
            lst[i] <= lst[i-1];
          end
          vld[0] <= take;
          lst[0] <= last_take;
        end
      end
    end
  end

  assign o_in_ready   = in_ready;
  assign o_stage_en   = stage_en;
  assign o_dict_wr_en = wr_en;
  assign o_dict_clear = (state == CLEAR);
  assign o_out_valid  = vld[PIPE_LAT-1];
  assign o_out_last   = lst[PIPE_LAT-1];
  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_compress_stage_ctrl.sv
`default_nettype none
// tb_compress_stage_ctrl: directed vectors for a 4-pair block with a 2-deep stage.
// Rev 1.0
module tb_compress_stage_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_abort;
  logic        i_in_valid;
  logic [63:0] i_in_data;
  logic        o_in_ready;
  logic [63:0] o_word;
  logic        o_stage_en;
  logic        o_dict_wr_en;
  logic        o_dict_clear;
  logic        i_out_ready;
  logic        o_out_valid;
  logic        o_out_last;
  logic        o_busy;
  logic        o_done;

  int vectors;
  int miscompares;

  compress_stage_ctrl #(
    .WIDTH      (64),
    .BLOCK_PAIRS(4),
    .PIPE_LAT   (2),
    .CNT_W      (2)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_word      (o_word),
    .o_stage_en  (o_stage_en),
    .o_dict_wr_en(o_dict_wr_en),
    .o_dict_clear(o_dict_clear),
    .i_out_ready (i_out_ready),
    .o_out_valid (o_out_valid),
    .o_out_last  (o_out_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Flag order: in_ready stage_en dict_wr_en out_valid out_last busy done dict_clear
  function automatic logic [7:0] flags();
    return {o_in_ready, o_stage_en, o_dict_wr_en, o_out_valid,
            o_out_last, o_busy, o_done, o_dict_clear};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then cross the next edge.
  task automatic cyc(input string tag, input bit st, input bit iv, input logic [63:0] d,
                     input bit ordy, input bit ab, input logic [7:0] ef,
                     input bit cw, input logic [63:0] ew);
    i_start     = st;
    i_in_valid  = iv;
    i_in_data   = d;
    i_out_ready = ordy;
    i_abort     = ab;
    #1;
    chk({tag, ".flags"}, {56'd0, flags()}, {56'd0, ef});
    if (cw) chk({tag, ".word"}, o_word, ew);
    step();
  endtask

  // Unstalled 4-pair block starting from IDLE, ending after the DONE edge.
  task automatic full_block(input string tag, input bit hold_start, input logic [63:0] base);
    logic [7:0] ef [10];
    ef = '{8'b0000_0000, 8'b0000_0101, 8'b1100_0100, 8'b1110_0100, 8'b1111_0100,
           8'b1111_0100, 8'b0111_0100, 8'b0101_1100, 8'b0100_0100, 8'b0000_0110};
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("%s.c%0d", tag, i),
          (i == 0) ? 1'b1 : hold_start,
          (i >= 1 && i <= 5),
          base + 64'((i >= 2) ? i - 2 : 0),
          1'b1, 1'b0, ef[i],
          (i >= 3),
          base + 64'((i - 3 > 3) ? 3 : ((i >= 3) ? i - 3 : 0)));
    end
  endtask

  initial begin
    logic [63:0] q0;
    vectors     = 0;
    miscompares = 0;
    i_reset     = 1'b0;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.flags", {56'd0, flags()}, 64'd0);
    chk("rst.word", o_word, 64'd0);
    i_reset = 1'b1;
    step();

    // Plain block
    full_block("t1", 1'b0, 64'h1111_0000_0000_0000);
    cyc("t1.idle", 0, 0, 0, 1, 0, 8'b0000_0000, 1, 64'h1111_0000_0000_0003);

    // Backpressure while results are valid
    q0 = 64'h0000_0000_AABB_CCDD;
    cyc("t2.c0",  1, 0, 0,      1, 0, 8'b0000_0000, 0, 0);
    cyc("t2.c1",  0, 1, q0,     1, 0, 8'b0000_0101, 0, 0);
    cyc("t2.c2",  0, 1, q0,     1, 0, 8'b1100_0100, 0, 0);
    cyc("t2.c3",  0, 1, q0 + 1, 1, 0, 8'b1110_0100, 1, q0);
    cyc("t2.c4",  0, 1, q0 + 2, 0, 0, 8'b0011_0100, 1, q0 + 1);
    cyc("t2.c5",  0, 1, q0 + 2, 0, 0, 8'b0001_0100, 1, q0 + 1);
    cyc("t2.c6",  0, 1, q0 + 2, 0, 0, 8'b0001_0100, 1, q0 + 1);
    cyc("t2.c7",  0, 1, q0 + 2, 1, 0, 8'b1101_0100, 1, q0 + 1);
    cyc("t2.c8",  0, 1, q0 + 3, 1, 0, 8'b1111_0100, 1, q0 + 2);
    cyc("t2.c9",  0, 0, 0,      1, 0, 8'b0111_0100, 1, q0 + 3);
    cyc("t2.c10", 0, 0, 0,      1, 0, 8'b0101_1100, 1, q0 + 3);
    cyc("t2.c11", 0, 0, 0,      1, 0, 8'b0100_0100, 1, q0 + 3);
    cyc("t2.c12", 0, 0, 0,      1, 0, 8'b0000_0110, 1, q0 + 3);

    // Input bubbles
    cyc("t3.c0",  1, 0, 0,        1, 0, 8'b0000_0000, 0, 0);
    cyc("t3.c1",  0, 1, 64'h30,   1, 0, 8'b0000_0101, 0, 0);
    cyc("t3.c2",  0, 1, 64'h30,   1, 0, 8'b1100_0100, 0, 0);
    cyc("t3.c3",  0, 0, 0,        1, 0, 8'b1110_0100, 1, 64'h30);
    cyc("t3.c4",  0, 1, 64'h31,   1, 0, 8'b1101_0100, 1, 64'h30);
    cyc("t3.c5",  0, 0, 0,        1, 0, 8'b1110_0100, 1, 64'h31);
    cyc("t3.c6",  0, 1, 64'h32,   1, 0, 8'b1101_0100, 1, 64'h31);
    cyc("t3.c7",  0, 0, 0,        1, 0, 8'b1110_0100, 1, 64'h32);
    cyc("t3.c8",  0, 1, 64'h33,   1, 0, 8'b1101_0100, 1, 64'h32);
    cyc("t3.c9",  0, 0, 0,        1, 0, 8'b0110_0100, 1, 64'h33);
    cyc("t3.c10", 0, 0, 0,        1, 0, 8'b0101_1100, 1, 64'h33);
    cyc("t3.c11", 0, 0, 0,        1, 0, 8'b0100_0100, 1, 64'h33);
    cyc("t3.c12", 0, 0, 0,        1, 0, 8'b0000_0110, 1, 64'h33);

    // Abort after two accepts; the pair offered alongside the abort is dropped
    cyc("t4.c0", 1, 0, 0,      1, 0, 8'b0000_0000, 0, 0);
    cyc("t4.c1", 0, 1, 64'h40, 1, 0, 8'b0000_0101, 0, 0);
    cyc("t4.c2", 0, 1, 64'h40, 1, 0, 8'b1100_0100, 0, 0);
    cyc("t4.c3", 0, 1, 64'h41, 1, 0, 8'b1110_0100, 1, 64'h40);
    cyc("t4.c4", 1, 1, 64'h42, 1, 1, 8'b1111_0100, 1, 64'h41);
    cyc("t4.c5", 0, 0, 0,      1, 0, 8'b0000_0000, 1, 64'h41);
    cyc("t4.c6", 0, 0, 0,      1, 0, 8'b0000_0000, 1, 64'h41);
    full_block("t4.b", 1'b0, 64'h4400);

    // Start held through RUN/DRAIN/DONE is ignored; back-to-back blocks
    full_block("t5.a", 1'b1, 64'h5500);
    full_block("t5.b", 1'b0, 64'h5600);
    cyc("t5.idle", 0, 0, 0, 1, 0, 8'b0000_0000, 0, 0);

    // Asynchronous reset between edges while in RUN
    cyc("t6.c0", 1, 0, 0,      1, 0, 8'b0000_0000, 0, 0);
    cyc("t6.c1", 0, 1, 64'h60, 1, 0, 8'b0000_0101, 0, 0);
    cyc("t6.c2", 0, 1, 64'h60, 1, 0, 8'b1100_0100, 0, 0);
    cyc("t6.c3", 0, 1, 64'h61, 1, 0, 8'b1110_0100, 1, 64'h60);
    i_in_valid = 1'b1;
    i_in_data  = 64'h62;
    #2;
    i_reset = 1'b0;
    #1;
    chk("t6.arst.flags", {56'd0, flags()}, 64'd0);
    chk("t6.arst.word", o_word, 64'd0);
    step();
    chk("t6.held.flags", {56'd0, flags()}, 64'd0);
    i_in_valid = 1'b0;
    i_reset    = 1'b1;
    step();
    chk("t6.rel.flags", {56'd0, flags()}, 64'd0);
    full_block("t6.b", 1'b0, 64'h6600);
    cyc("t6.idle", 0, 0, 0, 1, 0, 8'b0000_0000, 1, 64'h6603);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
